// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-2 FFT butterfly sequencer.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int BF_PHASES = 5;

    localparam logic [2:0] PH_RD_A    = 3'd0;
    localparam logic [2:0] PH_RD_B    = 3'd1;
    localparam logic [2:0] PH_COMPUTE = 3'd2;
    localparam logic [2:0] PH_WR_A    = 3'd3;
    localparam logic [2:0] PH_WR_B    = 3'd4;

endpackage

// File: rtl/fft_phase_counter.sv
// Mod-BF_PHASES butterfly phase counter with enable and synchronous clear.
// The wrap flag is a plain compare of the phase register, qualified by enable.
module fft_phase_counter
    import fft_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_en,
    input  logic       i_clr,
    output logic [2:0] o_phase,
    output logic       o_wrap
);

    localparam logic [2:0] PH_LAST = 3'(BF_PHASES - 1);

    logic [2:0] r_phase;

    // Step through the butterfly phases while enabled, folding back to RD_A after WR_B.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_phase <= '0;
        end else if (i_clr) begin
            r_phase <= '0;
        end else if (i_en) begin
            r_phase <= (r_phase == PH_LAST) ? 3'd0 : r_phase + 3'd1;
        end
    end

    assign o_phase = r_phase;
    assign o_wrap  = i_en && (r_phase == PH_LAST);

endmodule

// File: rtl/fft_bf_sequencer.sv
// Stage/butterfly sequencer for an in-place radix-2 FFT: walks every stage and
// butterfly, drives RAM addresses, twiddle index and strobes, and inserts a
// drain gap between stages so in-flight writes retire.
module fft_bf_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N      = 5,
    parameter int PIPE_DRAIN = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(LOG2N)-1:0] stage,
    output logic [2:0]               phase,
    output logic [LOG2N-1:0]         addr_a,
    output logic [LOG2N-1:0]         addr_b,
    output logic [LOG2N-2:0]         tw_idx,
    output logic                     rd_en,
    output logic                     wr_en,
    output logic                     sel_b
);

    localparam int SW = $clog2(LOG2N);
    localparam int KW = LOG2N - 1;
    localparam int DW = (PIPE_DRAIN > 1) ? $clog2(PIPE_DRAIN) : 1;

    localparam logic [SW-1:0] STAGE_LAST   = SW'(LOG2N - 1);
    localparam logic [KW-1:0] K_LAST       = '1;
    localparam logic [DW-1:0] DRAIN_LAST   = DW'((PIPE_DRAIN > 0) ? PIPE_DRAIN - 1 : 0);
    localparam logic [SW:0]   TW_SHIFT_TOP = (SW + 1)'(LOG2N - 1);

    state_t          r_state;
    logic [SW-1:0]   r_stage;
    logic [KW-1:0]   r_k;
    logic [DW-1:0]   r_drain;

    logic            w_run;
    logic            w_wrap;
    logic [2:0]      w_phase;
    logic [LOG2N-1:0] w_k_ext;
    logic [LOG2N-1:0] w_half;
    logic [LOG2N-1:0] w_pos;
    logic [LOG2N-1:0] w_group;
    logic [LOG2N-1:0] w_addr_a;
    logic [SW:0]      w_stage_p1;
    logic [SW:0]      w_tw_shift;
    logic [KW-1:0]    w_tw;

    assign w_run = (r_state == ST_RUN);

    fft_phase_counter u_phase (
        .clk     (clk),
        .rstn    (rstn),
        .i_en    (w_run),
        .i_clr   (abort),
        .o_phase (w_phase),
        .o_wrap  (w_wrap)
    );

    // Control FSM plus stage, butterfly and drain counters; abort clears everything.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_stage <= '0;
            r_k     <= '0;
            r_drain <= '0;
        end else if (abort) begin
            r_state <= ST_IDLE;
            r_stage <= '0;
            r_k     <= '0;
            r_drain <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_stage <= '0;
                        r_k     <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_wrap) begin
                        if (r_k == K_LAST) begin
                            r_k <= '0;
                            if (r_stage == STAGE_LAST) begin
                                r_state <= ST_DONE;
                                r_stage <= '0;
                            end else if (PIPE_DRAIN == 0) begin
                                r_stage <= r_stage + 1'b1;
                            end else begin
                                r_state <= ST_DRAIN;
                                r_drain <= '0;
                            end
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == DRAIN_LAST) begin
                        r_state <= ST_RUN;
                        r_stage <= r_stage + 1'b1;
                        r_drain <= '0;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Butterfly k of stage s pairs addr_a with addr_a + 2^s; group/pos split k around bit s.
    assign w_k_ext    = {1'b0, r_k};
    assign w_half     = {{(LOG2N-1){1'b0}}, 1'b1} << r_stage;
    assign w_pos      = w_k_ext & (w_half - 1'b1);
    assign w_group    = w_k_ext >> r_stage;
    assign w_stage_p1 = {1'b0, r_stage} + 1'b1;
    assign w_addr_a   = (w_group << w_stage_p1) | w_pos;
    assign w_tw_shift = TW_SHIFT_TOP - {1'b0, r_stage};
    assign w_tw       = w_pos[KW-1:0] << w_tw_shift;

    assign addr_a = w_run ? w_addr_a : '0;
    assign addr_b = w_run ? (w_addr_a + w_half) : '0;
    assign tw_idx = w_run ? w_tw : '0;

    assign rd_en = w_run && ((w_phase == PH_RD_A) || (w_phase == PH_RD_B));
    assign wr_en = w_run && ((w_phase == PH_WR_A) || (w_phase == PH_WR_B));
    assign sel_b = w_run && ((w_phase == PH_RD_B) || (w_phase == PH_WR_B));

    assign busy  = w_run || (r_state == ST_DRAIN);
    assign done  = (r_state == ST_DONE);
    assign stage = r_stage;
    assign phase = w_phase;

endmodule
